comparator: RTL and testbench

32-bit operand comparator in the pipeline's decode stage, used for branch resolution. It produces a purely combinational equality flag `out` for same-cycle branch decisions. It also produces a registered set of equality and magnitude flags for downstream hazard and branch logic. An optional compile-time statistics block counts compares and matches.

---
 rtl/comparator.sv | 106 ++++++++++
 tb/tb_comparator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/comparator.sv
// Decode-stage 32-bit operand comparator: combinational equality plus registered branch flags.
// Optional statistics counters are built when COMPARATOR_STATS_EN is defined.
module comparator (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic        valid_in,
    output logic        out,
    output logic        valid_q,
    output logic        eq_q,
    output logic        ne_q,
    output logic        lt_q,
    output logic        ltu_q,
    output logic        ge_q,
    output logic        geu_q,
    output logic [15:0] cmp_count,
    output logic [15:0] match_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              w_eq;
    logic              w_lt;
    logic              w_ltu;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    assign w_a   = input1;
    assign w_b   = input2;
    assign w_eq  = (w_a == w_b);
    assign w_lt  = ($signed(w_a) < $signed(w_b));
    assign w_ltu = (w_a < w_b);

    // Same-cycle branch decision path, independent of clock and reset.
    assign out = w_eq;

    logic r_valid;
    logic r_eq;
    logic r_lt;
    logic r_ltu;

    // Flags load only on valid cycles; the complementary flags are derived so they can never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_ltu   <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_eq  <= w_eq;
                r_lt  <= w_lt;
                r_ltu <= w_ltu;
            end
        end
    end

    logic r_loaded;

    // Complements stay 0 after reset until the first load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loaded <= 1'b0;
        end else if (valid_in) begin
            r_loaded <= 1'b1;
        end
    end

    assign valid_q = r_valid;
    assign eq_q    = r_eq;
    assign lt_q    = r_lt;
    assign ltu_q   = r_ltu;
    assign ne_q    = r_loaded & ~r_eq;
    assign ge_q    = r_loaded & ~r_lt;
    assign geu_q   = r_loaded & ~r_ltu;

`ifdef COMPARATOR_STATS_EN
    logic [CNT_W-1:0] r_cmp_count;
    logic [CNT_W-1:0] r_match_count;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_count   <= '0;
            r_match_count <= '0;
        end else if (valid_in) begin
            if (r_cmp_count != {CNT_W{1'b1}}) begin
                r_cmp_count <= r_cmp_count + CNT_W'(1);
            end
            if (w_eq && (r_match_count != {CNT_W{1'b1}})) begin
                r_match_count <= r_match_count + CNT_W'(1);
            end
        end
    end

    assign cmp_count   = r_cmp_count;
    assign match_count = r_match_count;
`else
    assign cmp_count   = '0;
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed vectors plus randomized steps against a value-level model.
// Counter expectations follow COMPARATOR_STATS_EN.
module tb_comparator;

    logic        clk;
    logic        rst;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        valid_in;
    logic        out;
    logic        valid_q;
    logic        eq_q;
    logic        ne_q;
    logic        lt_q;
    logic        ltu_q;
    logic        ge_q;
    logic        geu_q;
    logic [15:0] cmp_count;
    logic [15:0] match_count;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_valid, m_eq, m_ne, m_lt, m_ltu, m_ge, m_geu;
    int m_cmp, m_match;

    comparator dut (
        .clk        (clk),
        .rst        (rst),
        .input1     (input1),
        .input2     (input2),
        .valid_in   (valid_in),
        .out        (out),
        .valid_q    (valid_q),
        .eq_q       (eq_q),
        .ne_q       (ne_q),
        .lt_q       (lt_q),
        .ltu_q      (ltu_q),
        .ge_q       (ge_q),
        .geu_q      (geu_q),
        .cmp_count  (cmp_count),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint as_signed(input logic [31:0] x);
        longint v;
        v = longint'(x);
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
        return v;
    endfunction

    function automatic longint as_unsigned(input logic [31:0] x);
        return longint'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("valid_q", 32'(valid_q), 32'(m_valid));
        chk("eq_q", 32'(eq_q), 32'(m_eq));
        chk("ne_q", 32'(ne_q), 32'(m_ne));
        chk("lt_q", 32'(lt_q), 32'(m_lt));
        chk("ltu_q", 32'(ltu_q), 32'(m_ltu));
        chk("ge_q", 32'(ge_q), 32'(m_ge));
        chk("geu_q", 32'(geu_q), 32'(m_geu));
        chk("cmp_count", 32'(cmp_count), 32'(m_cmp));
        chk("match_count", 32'(match_count), 32'(m_match));
    endtask

    // One clock step: apply operands, check combinational equality, clock, update model, check.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic v, input logic r, input bit full);
        int e;
        input1   = a;
        input2   = b;
        valid_in = v;
        rst      = r;
        e = (as_unsigned(a) == as_unsigned(b)) ? 1 : 0;
        #1;
        if (full) chk("out_comb", 32'(out), 32'(e));
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_eq = 0; m_ne = 0; m_lt = 0; m_ltu = 0; m_ge = 0; m_geu = 0;
            m_cmp = 0; m_match = 0;
        end else begin
            m_valid = v ? 1 : 0;
            if (v) begin
                m_eq  = e;
                m_ne  = 1 - e;
                m_lt  = (as_signed(a) < as_signed(b)) ? 1 : 0;
                m_ge  = 1 - m_lt;
                m_ltu = (as_unsigned(a) < as_unsigned(b)) ? 1 : 0;
                m_geu = 1 - m_ltu;
`ifdef COMPARATOR_STATS_EN
                m_cmp = (m_cmp < 65535) ? m_cmp + 1 : 65535;
                if (e == 1) m_match = (m_match < 65535) ? m_match + 1 : 65535;
`endif
            end
        end
        #1;
        if (full) begin
            check_regs();
            chk("out_after_edge", 32'(out), 32'(e));
        end
    endtask

    initial begin
        logic [31:0] pa [8];
        logic [31:0] pb [8];
        logic [31:0] a;
        logic [31:0] b;

        input1 = '0; input2 = '0; valid_in = 1'b0; rst = 1'b1;
        m_valid = 0; m_eq = 0; m_ne = 0; m_lt = 0; m_ltu = 0; m_ge = 0; m_geu = 0;
        m_cmp = 0; m_match = 0;

        // Pure combinational equality with no clocking involved
        input1 = 32'hFFFFFFFF; input2 = 32'hFFFFFFFF; #1 chk("comb_ff_ff", 32'(out), 32'd1);
        input2 = 32'h00000000; #1 chk("comb_ff_00", 32'(out), 32'd0);
        input1 = 32'h00000000; input2 = 32'hFFFFFFFF; #1 chk("comb_00_ff", 32'(out), 32'd0);
        input2 = 32'h00000000; #1 chk("comb_00_00", 32'(out), 32'd1);

        // Reset state
        step(32'h0, 32'h1, 1'b0, 1'b1, 1'b1);
        step(32'h0, 32'h1, 1'b0, 1'b1, 1'b1);

        // Eight valid compares: seven listed pairs plus -1 vs 0
        pa[0] = 32'hFFFFFFFF; pb[0] = 32'hFFFFFFFF;
        pa[1] = 32'hFFFFFFFF; pb[1] = 32'h00000000;
        pa[2] = 32'h00000000; pb[2] = 32'hFFFFFFFF;
        pa[3] = 32'h00000000; pb[3] = 32'h00000000;
        pa[4] = 32'h11111111; pb[4] = 32'h11111111;
        pa[5] = 32'hABCDEF12; pb[5] = 32'h12345678;
        pa[6] = 32'hABCDEF12; pb[6] = 32'hABCDEF12;
        pa[7] = 32'hFFFFFFFF; pb[7] = 32'h00000000;
        for (int i = 0; i < 8; i++) step(pa[i], pb[i], 1'b1, 1'b0, 1'b1);

        // Explicit expectations for -1 vs 0 and stats totals
        chk("sign_lt_q", 32'(lt_q), 32'd1);
        chk("sign_ltu_q", 32'(ltu_q), 32'd0);
        chk("sign_ge_q", 32'(ge_q), 32'd0);
        chk("sign_geu_q", 32'(geu_q), 32'd1);
        chk("sign_ne_q", 32'(ne_q), 32'd1);
`ifdef COMPARATOR_STATS_EN
        chk("stats_cmp8", 32'(cmp_count), 32'd8);
        chk("stats_match4", 32'(match_count), 32'd4);
`else
        chk("stats_cmp_off", 32'(cmp_count), 32'd0);
        chk("stats_match_off", 32'(match_count), 32'd0);
`endif

        // Hold: invalid cycle keeps flags while out follows operands
        step(32'hABCDEF12, 32'hABCDEF12, 1'b0, 1'b0, 1'b1);
        chk("hold_lt_q", 32'(lt_q), 32'd1);
        chk("hold_valid_q", 32'(valid_q), 32'd0);

        // Reset beats valid_in on the same edge
        step(32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1);
        chk("rst_prio_eq_q", 32'(eq_q), 32'd0);
        chk("rst_prio_out", 32'(out), 32'd1);

        // Randomized traffic with biased operand relationships
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h80000000;
                2: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            step(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0), 1'b1);
        end

`ifdef COMPARATOR_STATS_EN
        // Saturation: both counters must stick at 0xFFFF
        step(32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 65540; i++) step(32'h1234, 32'h1234, 1'b1, 1'b0, 1'b0);
        step(32'h1234, 32'h1234, 1'b1, 1'b0, 1'b1);
        chk("sat_cmp", 32'(cmp_count), 32'h0000FFFF);
        chk("sat_match", 32'(match_count), 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
